cpu_instr_prefetch_reg: RTL and testbench
=========================================

Name: cpu_instr_prefetch_reg

Overview:
Parametrised successor to the CPU's single instruction register. It is a DEPTH-entry prefetch queue between program memory and decode, and holds each instruction word with its PC tag. It has valid/ready handshakes on both sides, a flush for branches and taken skips, and a defined NOP when empty. This lets fetch run ahead of decode without stalling the PIC10-compatible pipeline.

Parameters:
INSTR_W, 12, instruction word width (PIC10 baseline = 12)
ADDR_W, 9, PC tag width
DEPTH, 2, queue entries; power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
fetch_valid  in  1  program-memory word present
fetch_instr  in  INSTR_W  instruction word
fetch_pc  in  ADDR_W  PC of fetch_instr
fetch_ready  out  1  queue can accept a word
flush  in  1  discard all queued words (branch/skip taken)
issue_valid  out  1  head entry valid
issue_instr  out  INSTR_W  head instruction; NOP (all zero) when empty
issue_pc  out  ADDR_W  head PC tag; zero when empty
issue_ready  in  1  decode accepts head
count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (async, any time including mid-transfer): rd_ptr, wr_ptr, count = 0. Outputs: issue_valid=0, issue_instr=0, issue_pc=0, fetch_ready=1. Storage contents are don't-care.
- push = fetch_valid & fetch_ready; pop = issue_valid & issue_ready.
- fetch_ready = (count != DEPTH). It is combinational from count only. There is no full-bypass, so a push into a full queue is never accepted, even if a pop happens that cycle.
- issue_valid = (count != 0). issue_instr/issue_pc = entry[rd_ptr] when valid, else 0. This output path is combinational from registered state only.
- Latency: a word pushed at edge N is visible on issue_* after edge N. There is no same-cycle fetch-to-issue bypass.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any occupancy 1..DEPTH-1, and also at DEPTH-1 -> stays DEPTH-1.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is a separate register and is never derived from the pointers.
- flush has priority over push and pop. At the next edge rd_ptr=wr_ptr=0 and count=0. A push presented in the flush cycle is dropped. A pop in the flush cycle is treated as consumed; decode must ignore it.
- Order is FIFO and entries are never reordered. issue_* holds stable while issue_valid=1 and issue_ready=0.

Optional Feature:
Macro CPU_PREFETCH_SKIP_EN.
- With it: add input skip (1 bit) and a sticky skip_pending register, reset to 0.
  - skip=1 sets skip_pending.
  - While skip_pending=1, issue_instr is forced to 0 (NOP) while issue_pc is passed unchanged. This implements PIC10 skip-next semantics.
  - The flag clears on the first pop after it was set.
  - If skip and pop occur in the same cycle, the popped word is issued normally and the *next* word is NOP'd.
  - flush clears skip_pending.
- Without it: no skip port, no register, and issue_instr always reflects the entry.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR constant (12'h000)
  - default INSTR_W/ADDR_W localparams
  - $clog2-based COUNT_W helper
- One natural sub-module: cpu_prefetch_mem, a DEPTH x (INSTR_W+ADDR_W) register array with one synchronous write port and one asynchronous read port. Pointers, count, handshake and the skip logic stay in the top module.

Test Plan:
- Reset then idle -> fetch_ready=1, issue_valid=0, issue_instr=12'h000, count=0. Assert rst mid-burst -> same values immediately, before any clock edge.
- Push 12'hA05@pc 9'h010, then 12'h0F3@pc 9'h011, with issue_ready=0 -> count=2 and fetch_ready=0. A third push is held off and the head stays A05/010.
- Queue full, issue_ready=1, fetch_valid=1 -> pops A05 with no push that cycle. Next cycle head=0F3 and fetch_ready=1. Sustained push+pop over 10 words streams in order with count constant.
- Queue holding 2 entries, flush=1 together with fetch_valid=1 -> next cycle count=0 and issue_valid=0. The word from the flush cycle never appears.
- Pointer wrap: DEPTH=4, push/pop 9 words -> every word is issued in order with the correct PC tag.
- CPU_PREFETCH_SKIP_EN: head=12'hC01@020 and next=12'h2A5@021; pulse skip, then pop twice -> the first pop yields C01 and the second yields 000@021. Then flush with skip_pending set -> the flag is cleared.

Source files
------------

// File: rtl/cpu_instr_prefetch_reg_pkg.sv
// Shared constants for the instruction prefetch queue: NOP encoding, default widths,
// and the occupancy-counter width helper.
package cpu_pkg;

    localparam int DEF_INSTR_W = 12;
    localparam int DEF_ADDR_W  = 9;

    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 12'h000;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cpu_instr_prefetch_reg_if.sv
// Fetch-side and issue-side handshake bundle for the prefetch queue.
// Optional skip input exists only when CPU_PREFETCH_SKIP_EN is defined.
interface cpu_instr_prefetch_reg_if
    import cpu_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = 2
);
    localparam int COUNT_W = count_w(DEPTH);

    logic               fetch_valid;
    logic [INSTR_W-1:0] fetch_instr;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               fetch_ready;
    logic               flush;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic [ADDR_W-1:0]  issue_pc;
    logic               issue_ready;
    logic [COUNT_W-1:0] count;
`ifdef CPU_PREFETCH_SKIP_EN
    logic               skip;
`endif

    // master: program memory + decode side; slave: the queue itself
    modport master (
        output fetch_valid, fetch_instr, fetch_pc, flush, issue_ready,
`ifdef CPU_PREFETCH_SKIP_EN
        output skip,
`endif
        input  fetch_ready, issue_valid, issue_instr, issue_pc, count
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, flush, issue_ready,
`ifdef CPU_PREFETCH_SKIP_EN
        input  skip,
`endif
        output fetch_ready, issue_valid, issue_instr, issue_pc, count
    );

endinterface

// File: rtl/cpu_prefetch_mem.sv
// DEPTH x W storage array: one synchronous write port, one asynchronous read port.
// Contents are not reset; occupancy tracking in the parent decides what is meaningful.
module cpu_prefetch_mem #(
    parameter int W     = 21,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_instr_prefetch_reg.sv
// DEPTH-entry instruction prefetch queue with PC tags; issue_* shows NOP/zero when empty.
// Latency one edge push-to-issue, no bypass; fetch_ready drops when full; optional CPU_PREFETCH_SKIP_EN.
module cpu_instr_prefetch_reg
    import cpu_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = 2
) (
    input logic                   clk,
    input logic                   rst,
    cpu_instr_prefetch_reg_if.slave bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = count_w(DEPTH);
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [COUNT_W-1:0] count_q;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               nop_head;

    assign bus.fetch_ready = (count_q != COUNT_W'(DEPTH));
    assign bus.issue_valid = (count_q != '0);
    assign bus.count       = count_q;

    assign push = bus.fetch_valid & bus.fetch_ready;
    assign pop  = bus.issue_valid & bus.issue_ready;

    cpu_prefetch_mem #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~bus.flush),
        .waddr (wr_ptr),
        .wdata ({bus.fetch_instr, bus.fetch_pc}),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // Flush wins over push and pop; count is tracked on its own, not from pointer difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CPU_PREFETCH_SKIP_EN
    logic skip_pending;

    // A skip arriving with a pop targets the word after the one being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_pending <= 1'b0;
        end else if (bus.flush) begin
            skip_pending <= 1'b0;
        end else if (bus.skip) begin
            skip_pending <= 1'b1;
        end else if (pop) begin
            skip_pending <= 1'b0;
        end
    end

    assign nop_head = skip_pending;
`else
    assign nop_head = 1'b0;
`endif

    assign head_instr = head_entry[ENTRY_W-1:ADDR_W];
    assign head_pc    = head_entry[ADDR_W-1:0];

    assign bus.issue_instr = (bus.issue_valid && !nop_head) ? head_instr : INSTR_W'(NOP_INSTR);
    assign bus.issue_pc    = bus.issue_valid ? head_pc : '0;

endmodule

// File: tb/tb_cpu_instr_prefetch_reg.sv
// Directed checks of the prefetch queue at DEPTH=2 (handshake, flush, reset) and DEPTH=4 (wrap).
module tb_cpu_instr_prefetch_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_instr_prefetch_reg_if #(.INSTR_W(12), .ADDR_W(9), .DEPTH(2)) b2 ();
    cpu_instr_prefetch_reg_if #(.INSTR_W(12), .ADDR_W(9), .DEPTH(4)) b4 ();

    cpu_instr_prefetch_reg #(.INSTR_W(12), .ADDR_W(9), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    cpu_instr_prefetch_reg #(.INSTR_W(12), .ADDR_W(9), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string name, input logic fr, input logic iv,
                        input logic [11:0] ins, input logic [8:0] pc, input logic [1:0] cnt);
        chk({name, ".fetch_ready"}, 32'(b2.fetch_ready), 32'(fr));
        chk({name, ".issue_valid"}, 32'(b2.issue_valid), 32'(iv));
        chk({name, ".issue_instr"}, 32'(b2.issue_instr), 32'(ins));
        chk({name, ".issue_pc"},    32'(b2.issue_pc),    32'(pc));
        chk({name, ".count"},       32'(b2.count),       32'(cnt));
    endtask

    typedef struct {
        logic        fv;
        logic [11:0] instr;
        logic [8:0]  pc;
        logic        fl;
        logic        ir;
        logic        e_fr;
        logic        e_iv;
        logic [11:0] e_instr;
        logic [8:0]  e_pc;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vt[8];

    logic [20:0] exp_q[$];

    initial begin
        // inputs apply for one edge; expectations are post-edge outputs
        vt[0] = '{1'b1, 12'hA05, 9'h010, 1'b0, 1'b0, 1'b1, 1'b1, 12'hA05, 9'h010, 2'd1};
        vt[1] = '{1'b1, 12'h0F3, 9'h011, 1'b0, 1'b0, 1'b0, 1'b1, 12'hA05, 9'h010, 2'd2};
        vt[2] = '{1'b1, 12'h777, 9'h012, 1'b0, 1'b0, 1'b0, 1'b1, 12'hA05, 9'h010, 2'd2};
        vt[3] = '{1'b1, 12'h777, 9'h012, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0F3, 9'h011, 2'd1};
        vt[4] = '{1'b1, 12'h777, 9'h012, 1'b0, 1'b1, 1'b1, 1'b1, 12'h777, 9'h012, 2'd1};
        vt[5] = '{1'b1, 12'h888, 9'h013, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777, 9'h012, 2'd2};
        vt[6] = '{1'b1, 12'h999, 9'h014, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 9'h000, 2'd0};
        vt[7] = '{1'b0, 12'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 9'h000, 2'd0};

        b2.fetch_valid = 0; b2.fetch_instr = '0; b2.fetch_pc = '0; b2.flush = 0; b2.issue_ready = 0;
        b4.fetch_valid = 0; b4.fetch_instr = '0; b4.fetch_pc = '0; b4.flush = 0; b4.issue_ready = 0;
`ifdef CPU_PREFETCH_SKIP_EN
        b2.skip = 0; b4.skip = 0;
`endif
        #12 rst = 1'b0;
        step();
        step();
        chk2("reset_idle", 1'b1, 1'b0, 12'h000, 9'h000, 2'd0);

        foreach (vt[i]) begin
            b2.fetch_valid = vt[i].fv; b2.fetch_instr = vt[i].instr; b2.fetch_pc = vt[i].pc;
            b2.flush = vt[i].fl; b2.issue_ready = vt[i].ir;
            step();
            chk2($sformatf("vec%0d", i), vt[i].e_fr, vt[i].e_iv, vt[i].e_instr, vt[i].e_pc, vt[i].e_cnt);
        end

        // sustained push+pop stream of 10 words at occupancy 1
        b2.fetch_valid = 1; b2.fetch_instr = 12'h100; b2.fetch_pc = 9'h040; b2.issue_ready = 0;
        step();
        chk2("stream0", 1'b1, 1'b1, 12'h100, 9'h040, 2'd1);
        for (int k = 1; k < 10; k++) begin
            b2.fetch_instr = 12'h100 + 12'(k); b2.fetch_pc = 9'h040 + 9'(k); b2.issue_ready = 1;
            step();
            chk2($sformatf("stream%0d", k), 1'b1, 1'b1, 12'h100 + 12'(k), 9'h040 + 9'(k), 2'd1);
        end
        b2.fetch_valid = 0; b2.issue_ready = 1;
        step();
        chk2("stream_drain", 1'b1, 1'b0, 12'h000, 9'h000, 2'd0);

        // asynchronous reset in the middle of a burst, observed before the next edge
        b2.issue_ready = 0; b2.fetch_valid = 1; b2.fetch_instr = 12'h5A5; b2.fetch_pc = 9'h055;
        step();
        step();
        chk("burst_fill.count", 32'(b2.count), 32'd2);
        #1 rst = 1'b1;
        #1 chk2("async_rst", 1'b1, 1'b0, 12'h000, 9'h000, 2'd0);
        #1 rst = 1'b0;
        b2.fetch_valid = 0;
        step();
        chk2("post_rst", 1'b1, 1'b0, 12'h000, 9'h000, 2'd0);

`ifdef CPU_PREFETCH_SKIP_EN
        b2.fetch_valid = 1; b2.fetch_instr = 12'hC01; b2.fetch_pc = 9'h020;
        step();
        b2.fetch_instr = 12'h2A5; b2.fetch_pc = 9'h021;
        step();
        b2.fetch_valid = 0;
        chk2("skip_pre", 1'b0, 1'b1, 12'hC01, 9'h020, 2'd2);
        b2.skip = 1; b2.issue_ready = 1;
        step();
        b2.skip = 0;
        chk2("skip_nop", 1'b1, 1'b1, 12'h000, 9'h021, 2'd1);
        step();
        b2.issue_ready = 0;
        chk2("skip_drain", 1'b1, 1'b0, 12'h000, 9'h000, 2'd0);
        b2.fetch_valid = 1; b2.fetch_instr = 12'hE0E; b2.fetch_pc = 9'h022;
        step();
        b2.fetch_valid = 0;
        chk2("skip_cleared_by_pop", 1'b1, 1'b1, 12'hE0E, 9'h022, 2'd1);
        b2.skip = 1;
        step();
        b2.skip = 0;
        chk2("skip_set", 1'b1, 1'b1, 12'h000, 9'h022, 2'd1);
        b2.flush = 1;
        step();
        b2.flush = 0;
        b2.fetch_valid = 1; b2.fetch_instr = 12'hD0D; b2.fetch_pc = 9'h030;
        step();
        b2.fetch_valid = 0;
        chk2("skip_cleared_by_flush", 1'b1, 1'b1, 12'hD0D, 9'h030, 2'd1);
`endif

        // DEPTH=4 pointer wrap with a reference queue and irregular decode acceptance
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            while (got < 9 && cyc < 60) begin
                logic push_m, pop_m;
                b4.fetch_valid = (sent < 9);
                b4.fetch_instr = 12'h300 + 12'(sent);
                b4.fetch_pc    = 9'h080 + 9'(sent);
                b4.issue_ready = (cyc % 3 != 2);
                push_m = b4.fetch_valid && (exp_q.size() != 4);
                pop_m  = b4.issue_ready && (exp_q.size() != 0);
                if (pop_m) begin
                    chk($sformatf("wrap_word%0d", got), 32'({b4.issue_instr, b4.issue_pc}), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                    got++;
                end
                if (push_m) begin
                    exp_q.push_back({12'h300 + 12'(sent), 9'h080 + 9'(sent)});
                    sent++;
                end
                step();
                chk($sformatf("wrap_count_c%0d", cyc), 32'(b4.count), 32'(exp_q.size()));
                cyc++;
            end
            chk("wrap_all_issued", 32'(got), 32'd9);
            b4.fetch_valid = 0; b4.issue_ready = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
